// File: rtl/blind_spot.sv
// ---------------------------------------------------------------------------
// blind_spot
//   Registered blind-spot warning indicator for the body control module.
//   The left and right blind-spot sensors are each qualified by an
//   independent consecutive-sample debounce filter. The resulting 2-bit
//   warning drives the mirror indicators. A warning is raised only after
//   DEBOUNCE_CYCLES consecutive high samples. It clears on the first low
//   sample.
//
//   Optional feature, macro BLIND_SPOT_HOLD_EN:
//     When this macro is defined, a qualified warning stays asserted for
//     HOLD_CYCLES edges after its sensor drops. The first low sample loads
//     the hold counter, and the bit clears on the edge where that counter
//     reaches zero. If the sensor re-qualifies during the hold, the hold is
//     cancelled. When the macro is undefined, no hold logic is built.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive high samples needed to raise a side (1..255)
//   CNT_W            width of the per-side debounce and hold counters
//   HOLD_CYCLES      hold length after the sensor drops (hold build only)
//
// Ports
//   CLK         in   1  single clock, rising edge
//   RST         in   1  synchronous, active-high reset
//   right_side  in   1  1 = object in the right blind spot
//   left_side   in   1  1 = object in the left blind spot
//   blind       out  2  registered warning, [0] = right, [1] = left
//
// Inputs are assumed synchronous to CLK. The outputs come straight from
// flops, so there is no path from the inputs to blind within a cycle.
// ---------------------------------------------------------------------------
module blind_spot #(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int CNT_W           = 8,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       right_side,
    input  logic       left_side,
    output logic [1:0] blind
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    // Reject configurations in which the counters cannot hold their targets.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        DEBOUNCE_CYCLES >= (1 << CNT_W) || HOLD_CYCLES < 0 ||
        HOLD_CYCLES >= (1 << CNT_W)) begin : g_bad_params
        $error("blind_spot: DEBOUNCE_CYCLES/HOLD_CYCLES out of range for CNT_W");
    end

    // Bit positions match the blind output: [0] = right, [1] = left.
    logic [1:0] sense;
    assign sense = {left_side, right_side};

    for (genvar s = 0; s < 2; s++) begin : g_side
        logic [CNT_W-1:0] deb_cnt;
        logic [CNT_W-1:0] deb_next;
        logic             qualified;
        logic             warn;

        // The debounce count saturates at DEBOUNCE_CYCLES. A side stays
        // qualified for as long as its sensor remains high.
        always_comb begin
            deb_next  = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + CNT_W'(1);
            qualified = sense[s] && (deb_next == DEB_MAX);
        end

`ifdef BLIND_SPOT_HOLD_EN
        localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

        // A non-zero hold_cnt means a hold is running.
        logic [CNT_W-1:0] hold_cnt;

        always_ff @(posedge CLK) begin
            if (RST) begin
                deb_cnt  <= '0;
                hold_cnt <= '0;
                warn     <= 1'b0;
            end else begin
                deb_cnt <= sense[s] ? deb_next : '0;
                if (qualified) begin
                    // A fresh qualification cancels any running hold.
                    warn     <= 1'b1;
                    hold_cnt <= '0;
                end else if (hold_cnt != '0) begin
                    // The hold counts down on every edge, whatever the
                    // sensor does. A high sample that has not re-qualified
                    // does not reload the counter.
                    hold_cnt <= hold_cnt - CNT_W'(1);
                    if (hold_cnt == CNT_W'(1)) begin
                        warn <= 1'b0;
                    end
                end else if (warn) begin
                    // This is the first low sample after qualification.
                    // The warning is held instead of being dropped.
                    if (HOLD_LOAD == '0) begin
                        warn <= 1'b0;
                    end else begin
                        hold_cnt <= HOLD_LOAD;
                    end
                end
            end
        end
`else
        always_ff @(posedge CLK) begin
            if (RST) begin
                deb_cnt <= '0;
                warn    <= 1'b0;
            end else begin
                deb_cnt <= sense[s] ? deb_next : '0;
                warn    <= qualified;
            end
        end
`endif

        assign blind[s] = warn;
    end

endmodule

// File: tb/tb_blind_spot.sv
// ---------------------------------------------------------------------------
// tb_blind_spot
//   Two instances share the clock and the reset:
//     dut1  DEBOUNCE_CYCLES = 1
//     dut3  DEBOUNCE_CYCLES = 3
//   Both instances use HOLD_CYCLES = 4. Each test row drives the inputs,
//   pushes the expected {blind3, blind1} onto exp_q, and clocks one edge.
//   The scenario task then pops the expected value and compares it with
//   both outputs.
// ---------------------------------------------------------------------------
module tb_blind_spot;

`ifdef BLIND_SPOT_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam int HOLD = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       r1 = 1'b0, l1 = 1'b0, r3 = 1'b0, l3 = 1'b0;
  logic [1:0] blind1, blind3;

  logic [3:0] exp_q[$];
  int         total = 0;
  int         bad = 0;

  // Model state for the random test. Index order is r1, l1, r3, l3.
  int run_len[4];
  int since_q[4];

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  blind_spot #(.DEBOUNCE_CYCLES(1), .CNT_W(8), .HOLD_CYCLES(HOLD)) dut1 (
    .CLK(CLK), .RST(RST), .right_side(r1), .left_side(l1), .blind(blind1)
  );

  blind_spot #(.DEBOUNCE_CYCLES(3), .CNT_W(8), .HOLD_CYCLES(HOLD)) dut3 (
    .CLK(CLK), .RST(RST), .right_side(r3), .left_side(l3), .blind(blind3)
  );

  // ---------------- driver ----------------
  // Applies one row of stimulus, queues its expectation, and clocks one edge.
  // The outputs are then sampled 1 time unit after the edge.
  task automatic drive(input logic rst, input logic [1:0] s1, input logic [1:0] s3,
                       input logic [3:0] exp);
    RST = rst;
    {l1, r1} = s1;
    {l3, r3} = s3;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
  endtask

  // Reference model based on run length and on the time since the last
  // qualified edge.
  task automatic model_step(input logic rst, input logic [3:0] s, output logic [3:0] e);
    for (int k = 0; k < 4; k++) begin
      int deb;
      deb = (k < 2) ? 1 : 3;
      if (rst) begin
        run_len[k] = 0;
        since_q[k] = 1000;
      end else begin
        if (s[k]) begin
          if (run_len[k] < 1000) run_len[k]++;
        end else begin
          run_len[k] = 0;
        end
        if (run_len[k] >= deb) since_q[k] = 0;
        else if (since_q[k] < 1000) since_q[k]++;
      end
      e[k] = HOLD_EN ? (since_q[k] <= HOLD) : (run_len[k] >= deb);
    end
  endtask

  // Row layout: {rst, s1[1:0], s3[1:0], exp[3:0]}, where exp = {blind3, blind1}.
  task automatic test_reset();
    logic [3:0] e;
    drive(1'b1, 2'b00, 2'b00, 4'b0000);
    e = exp_q.pop_front();
    total++;
    if ({blind3, blind1} !== e) begin
      bad++;
      $display("FAIL reset: got=%b want=%b", {blind3, blind1}, e);
    end
  endtask

  task automatic test_single_side();
    logic [8:0] tbl[6];
    logic [3:0] e;
    tbl = '{
      {1'b1, 2'b00, 2'b00, 4'b0000},
      {1'b0, 2'b01, 2'b00, 4'b0001},
      {1'b1, 2'b01, 2'b00, 4'b0000},
      {1'b0, 2'b10, 2'b00, 4'b0010},
      {1'b0, 2'b11, 2'b00, 4'b0011},
      {1'b0, 2'b00, 2'b00, HOLD_EN ? 4'b0011 : 4'b0000}
    };
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      e = exp_q.pop_front();
      total++;
      if ({blind3, blind1} !== e) begin
        bad++;
        $display("FAIL single_side row %0d: got=%b want=%b", i, {blind3, blind1}, e);
      end
    end
  endtask

  task automatic test_debounce();
    logic [8:0] tbl[11];
    logic [3:0] e;
    tbl = '{
      {1'b1, 2'b00, 2'b00, 4'b0000},
      {1'b0, 2'b00, 2'b01, 4'b0000},
      {1'b0, 2'b00, 2'b01, 4'b0000},
      {1'b0, 2'b00, 2'b00, 4'b0000},
      {1'b0, 2'b00, 2'b01, 4'b0000},
      {1'b0, 2'b00, 2'b01, 4'b0000},
      {1'b0, 2'b00, 2'b01, 4'b0100},
      {1'b0, 2'b00, 2'b01, 4'b0100},
      {1'b0, 2'b00, 2'b11, 4'b0100},
      {1'b0, 2'b00, 2'b11, 4'b0100},
      {1'b0, 2'b00, 2'b01, 4'b0100}
    };
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      e = exp_q.pop_front();
      total++;
      if ({blind3, blind1} !== e) begin
        bad++;
        $display("FAIL debounce row %0d: got=%b want=%b", i, {blind3, blind1}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] tbl[8];
    logic [3:0] e;
    tbl = '{
      {1'b1, 2'b00, 2'b00, 4'b0000},
      {1'b0, 2'b11, 2'b11, 4'b0011},
      {1'b0, 2'b11, 2'b11, 4'b0011},
      {1'b0, 2'b11, 2'b11, 4'b1111},
      {1'b1, 2'b11, 2'b11, 4'b0000},
      {1'b0, 2'b11, 2'b11, 4'b0011},
      {1'b0, 2'b11, 2'b11, 4'b0011},
      {1'b0, 2'b11, 2'b11, 4'b1111}
    };
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      e = exp_q.pop_front();
      total++;
      if ({blind3, blind1} !== e) begin
        bad++;
        $display("FAIL reset_mid row %0d: got=%b want=%b", i, {blind3, blind1}, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [8:0] tbl[15];
    logic [3:0] e;
    tbl = '{
      {1'b1, 2'b00, 2'b00, 4'b0000},
      {1'b0, 2'b10, 2'b10, 4'b0010},
      {1'b0, 2'b00, 2'b10, HOLD_EN ? 4'b0010 : 4'b0000},
      {1'b0, 2'b00, 2'b10, HOLD_EN ? 4'b1010 : 4'b1000},
      {1'b0, 2'b00, 2'b00, HOLD_EN ? 4'b1010 : 4'b0000},
      {1'b0, 2'b00, 2'b10, HOLD_EN ? 4'b1010 : 4'b0000},
      {1'b0, 2'b00, 2'b10, HOLD_EN ? 4'b1000 : 4'b0000},
      {1'b0, 2'b10, 2'b00, HOLD_EN ? 4'b1010 : 4'b0010},
      {1'b0, 2'b00, 2'b00, HOLD_EN ? 4'b0010 : 4'b0000},
      {1'b0, 2'b10, 2'b00, 4'b0010},
      {1'b0, 2'b00, 2'b00, HOLD_EN ? 4'b0010 : 4'b0000},
      {1'b0, 2'b00, 2'b00, HOLD_EN ? 4'b0010 : 4'b0000},
      {1'b0, 2'b00, 2'b00, HOLD_EN ? 4'b0010 : 4'b0000},
      {1'b0, 2'b00, 2'b00, HOLD_EN ? 4'b0010 : 4'b0000},
      {1'b0, 2'b00, 2'b00, 4'b0000}
    };
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      e = exp_q.pop_front();
      total++;
      if ({blind3, blind1} !== e) begin
        bad++;
        $display("FAIL hold row %0d: got=%b want=%b", i, {blind3, blind1}, e);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] s;
    logic [3:0] e;
    logic       rst;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0) || ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 4; k++) s[k] = ($urandom_range(0, 3) != 0);
      model_step(rst, s, e);
      drive(rst, s[1:0], s[3:2], e);
      e = exp_q.pop_front();
      total++;
      if ({blind3, blind1} !== e) begin
        bad++;
        $display("FAIL random cycle %0d: got=%b want=%b", i, {blind3, blind1}, e);
      end
    end
  endtask

  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_single_side();
    test_debounce();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
